// File: rtl/matrix_load_sequencer_if.sv
// Host-side handshake, configuration and buffer write bus of the matrix load sequencer.
// The sequencer attaches through the slave modport; the host or register block uses master.
interface matrix_load_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DIM_W      = 3
);
    logic                  start;
    logic [DIM_W-1:0]      dim_n;
    logic [DIM_W-1:0]      dim_k;
    logic [DIM_W-1:0]      dim_m;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  write_enable_A;
    logic                  write_enable_B;
    logic [DATA_WIDTH-1:0] bus;
    logic                  busy;
    logic                  load_done;
    logic                  cfg_error;

    modport master (
        output start, dim_n, dim_k, dim_m, in_data, in_valid,
        input  in_ready, write_enable_A, write_enable_B, bus, busy, load_done, cfg_error
    );

    modport slave (
        input  start, dim_n, dim_k, dim_m, in_data, in_valid,
        output in_ready, write_enable_A, write_enable_B, bus, busy, load_done, cfg_error
    );
endinterface

// File: rtl/matrix_load_sequencer.sv
// Walks the padded A and B buffers row-major, writing host elements at real
// positions and zeros at pad positions, one registered strobe per position.
module matrix_load_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_DIM    = 4,
    parameter int DIM_W      = 3
) (
    input logic                    clk,
    input logic                    reset,
    matrix_load_sequencer_if.slave io
);
    // state  | meaning
    // IDLE   | waiting for start; dimensions checked here
    // LOAD_A | walking buffer A (dim_n rows x dim_k cols real)
    // LOAD_B | walking buffer B (dim_k rows x dim_m cols real)
    // DONE   | last B strobe on the bus; pulse load_done

    localparam int                CNT_W     = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(MAX_DIM - 1);
    localparam logic [DIM_W-1:0]  MAX_DIM_V = DIM_W'(MAX_DIM);

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, DONE} state_t;

    state_t                state;
    logic [CNT_W-1:0]      row;
    logic [CNT_W-1:0]      col;
    logic [CNT_W-1:0]      row_next;
    logic [CNT_W-1:0]      col_next;
    logic [DIM_W-1:0]      n_q;
    logic [DIM_W-1:0]      k_q;
    logic [DIM_W-1:0]      m_q;
    logic [DIM_W-1:0]      row_x;
    logic [DIM_W-1:0]      col_x;
    logic                  real_pos;
    logic                  last_pos;
    logic                  advance;
    logic                  dims_ok;
    logic [DATA_WIDTH-1:0] write_data;

    assign row_x = DIM_W'(row);
    assign col_x = DIM_W'(col);

    always_comb begin
        real_pos = 1'b0;
        case (state)
            LOAD_A:  real_pos = (row_x < n_q) && (col_x < k_q);
            LOAD_B:  real_pos = (row_x < k_q) && (col_x < m_q);
            default: real_pos = 1'b0;
        endcase
    end

    // Pad positions never wait on the host; real ones wait for in_valid.
    assign advance    = !real_pos || io.in_valid;
    assign last_pos   = (row == LAST_IDX) && (col == LAST_IDX);
    assign col_next   = (col == LAST_IDX) ? '0 : col + 1'b1;
    assign row_next   = (col == LAST_IDX) ? ((row == LAST_IDX) ? '0 : row + 1'b1) : row;
    assign write_data = real_pos ? io.in_data : '0;
    assign io.in_ready = real_pos && !reset;

    assign dims_ok = (io.dim_n != '0) && (io.dim_n <= MAX_DIM_V) &&
                     (io.dim_k != '0) && (io.dim_k <= MAX_DIM_V) &&
                     (io.dim_m != '0) && (io.dim_m <= MAX_DIM_V);

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            row               <= '0;
            col               <= '0;
            n_q               <= '0;
            k_q               <= '0;
            m_q               <= '0;
            io.write_enable_A <= 1'b0;
            io.write_enable_B <= 1'b0;
            io.bus            <= '0;
            io.busy           <= 1'b0;
            io.load_done      <= 1'b0;
            io.cfg_error      <= 1'b0;
        end else begin
            io.write_enable_A <= 1'b0;
            io.write_enable_B <= 1'b0;
            io.bus            <= '0;
            io.load_done      <= 1'b0;
            io.cfg_error      <= 1'b0;
            case (state)
                IDLE: begin
                    if (io.start) begin
                        if (dims_ok) begin
                            n_q     <= io.dim_n;
                            k_q     <= io.dim_k;
                            m_q     <= io.dim_m;
                            row     <= '0;
                            col     <= '0;
                            io.busy <= 1'b1;
                            state   <= LOAD_A;
                        end else begin
                            io.cfg_error <= 1'b1;
                        end
                    end
                end
                LOAD_A, LOAD_B: begin
                    if (advance) begin
                        if (state == LOAD_A) io.write_enable_A <= 1'b1;
                        else                 io.write_enable_B <= 1'b1;
                        io.bus <= write_data;
                        row    <= row_next;
                        col    <= col_next;
                        if (last_pos) state <= (state == LOAD_A) ? LOAD_B : DONE;
                    end
                end
                DONE: begin
                    io.load_done <= 1'b1;
                    io.busy      <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_load_sequencer.sv
// Scoreboarded bench for matrix_load_sequencer: expected buffer contents are built
// from the padding rule, a monitor pops and compares every write strobe.
module tb_matrix_load_sequencer;
    localparam int DW   = 32;
    localparam int MD   = 4;
    localparam int DIMW = 3;
    localparam int NPOS = MD * MD;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    matrix_load_sequencer_if #(.DATA_WIDTH(DW), .DIM_W(DIMW)) io ();

    matrix_load_sequencer #(.DATA_WIDTH(DW), .MAX_DIM(MD), .DIM_W(DIMW)) dut (
        .clk  (clk),
        .reset(reset),
        .io   (io)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [DW-1:0] exp_a[$];
    logic [DW-1:0] exp_b[$];
    logic [DW-1:0] host_q[$];
    int  cnt_a = 0, cnt_b = 0, done_cnt = 0, done_cyc = 0, consumed = 0;
    bit  drv_en = 1'b0;
    int  vmode  = 0;
    bit  tog    = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    // Monitor: every strobe must match the next expected element of its buffer.
    always @(negedge clk) begin
        if (io.write_enable_A === 1'b1 && io.write_enable_B === 1'b1)
            check("strobe_exclusive", 1, 0);
        if (io.write_enable_A === 1'b1) begin
            cnt_a++;
            if (exp_a.size() == 0) begin
                checks++; failures++;
                $display("FAIL a_extra_strobe: got bus %0d, expected no strobe", io.bus);
            end else check("a_data", io.bus, exp_a.pop_front());
        end
        if (io.write_enable_B === 1'b1) begin
            cnt_b++;
            if (exp_b.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_extra_strobe: got bus %0d, expected no strobe", io.bus);
            end else check("b_data", io.bus, exp_b.pop_front());
        end
        if (io.write_enable_A !== 1'b1 && io.write_enable_B !== 1'b1)
            check("bus_idle_zero", io.bus, 0);
        if (io.load_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Host driver: presents the head of host_q; a handshake pops it.
    initial begin
        forever begin
            @(negedge clk);
            if (drv_en) begin
                case (vmode)
                    0:       io.in_valid = 1'b1;
                    1:       begin io.in_valid = tog; tog = ~tog; end
                    default: io.in_valid = 1'($urandom_range(0, 1));
                endcase
                io.in_data = (host_q.size() != 0) ? host_q[0] : (32'hDEAD0000 | DW'($urandom_range(0, 255)));
                #1;
                if (io.in_valid && io.in_ready) begin
                    consumed++;
                    if (host_q.size() != 0) void'(host_q.pop_front());
                end
            end else begin
                io.in_valid = 1'b0;
                io.in_data  = '0;
            end
        end
    end

    // Reference: row-major walk, real positions take the next host element, others 0.
    task automatic build_expected(input int n, input int k, input int m, input logic [DW-1:0] data[$]);
        int idx = 0;
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++)
                if (r < n && c < k) exp_a.push_back(data[idx++]); else exp_a.push_back('0);
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++)
                if (r < k && c < m) exp_b.push_back(data[idx++]); else exp_b.push_back('0);
    endtask

    task automatic make_data(input int cnt, input bit seq, input int base, output logic [DW-1:0] data[$]);
        data.delete();
        for (int i = 0; i < cnt; i++) data.push_back(seq ? DW'(base + i) : DW'($urandom));
    endtask

    task automatic issue_start(input int n, input int k, input int m);
        io.dim_n = DIMW'(n);
        io.dim_k = DIMW'(k);
        io.dim_m = DIMW'(m);
        io.start = 1'b1;
    endtask

    task automatic run_load(input int n, input int k, input int m, input int mode,
                            input bit seq, input int base, input int exp_lat);
        logic [DW-1:0] data[$];
        int st, d0, t;
        make_data(n * k + k * m, seq, base, data);
        build_expected(n, k, m, data);
        host_q   = data;
        consumed = 0;
        cnt_a    = 0;
        cnt_b    = 0;
        d0       = done_cnt;
        vmode    = mode;
        tog      = 1'b1;
        drv_en   = 1'b1;
        issue_start(n, k, m);
        st = cyc;
        tick();
        io.start = 1'b0;
        check("busy_after_start", io.busy, 1);
        for (t = 0; t < 500 && done_cnt == d0; t++) tick();
        if (done_cnt == d0) begin
            checks++; failures++;
            $display("FAIL load_done_timeout: got no load_done, expected one within 500 cycles");
        end else begin
            if (exp_lat >= 0) check("load_latency", done_cyc - st, exp_lat);
            check("busy_at_done", io.busy, 0);
        end
        drv_en = 1'b0;
        check("a_strobe_count", cnt_a, NPOS);
        check("b_strobe_count", cnt_b, NPOS);
        check("host_consumed", consumed, n * k + k * m);
        check("exp_a_drained", exp_a.size(), 0);
        check("exp_b_drained", exp_b.size(), 0);
    endtask

    task automatic cfg_bad(input int n, input int k, input int m);
        cnt_a = 0;
        cnt_b = 0;
        issue_start(n, k, m);
        tick();
        io.start = 1'b0;
        check("cfg_error_pulse", io.cfg_error, 1);
        check("cfg_busy_low", io.busy, 0);
        tick();
        check("cfg_error_single", io.cfg_error, 0);
        repeat (3) tick();
        check("cfg_busy_stays_low", io.busy, 0);
        check("cfg_no_strobes", cnt_a + cnt_b, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, io.in_ready, 0);
        check({tag, "_we_a"}, io.write_enable_A, 0);
        check({tag, "_we_b"}, io.write_enable_B, 0);
        check({tag, "_bus"}, io.bus, 0);
        check({tag, "_busy"}, io.busy, 0);
        check({tag, "_load_done"}, io.load_done, 0);
        check({tag, "_cfg_error"}, io.cfg_error, 0);
    endtask

    initial begin
        logic [DW-1:0] data[$];
        int t, d0;
        reset       = 1'b1;
        io.in_valid = 1'b0;
        io.in_data  = '0;
        issue_start(2, 2, 2);
        repeat (2) tick();
        check_all_zero("reset");
        io.start = 1'b0;
        reset    = 1'b0;
        repeat (2) tick();
        check("busy_after_reset_start", io.busy, 0);
        check("no_strobe_after_reset", cnt_a + cnt_b, 0);

        run_load(2, 3, 2, 0, 1'b1, 1, 2 * NPOS + 2);
        run_load(4, 4, 4, 1, 1'b1, 1, -1);
        for (int i = 0; i < 4; i++)
            run_load($urandom_range(1, MD), $urandom_range(1, MD), $urandom_range(1, MD),
                     2, 1'b0, 0, -1);

        cfg_bad(0, 2, 2);
        cfg_bad(2, 2, 5);
        cfg_bad(3, 0, 1);

        // Abort mid-load after five A strobes.
        make_data(NPOS * 2, 1'b1, 100, data);
        build_expected(MD, MD, MD, data);
        host_q = data;
        cnt_a  = 0;
        cnt_b  = 0;
        vmode  = 0;
        drv_en = 1'b1;
        issue_start(MD, MD, MD);
        tick();
        io.start = 1'b0;
        for (t = 0; t < 100 && cnt_a < 5; t++) tick();
        check("abort_a_count", cnt_a, 5);
        drv_en      = 1'b0;
        io.in_valid = 1'b0;
        reset       = 1'b1;
        tick();
        check_all_zero("abort");
        reset = 1'b0;
        exp_a.delete();
        exp_b.delete();
        host_q.delete();
        tick();
        check("abort_no_more_strobes", cnt_a + cnt_b, 5);
        run_load(1, 1, 1, 0, 1'b1, 42, 2 * NPOS + 2);

        // start pulsed during LOAD_B must be ignored.
        d0 = done_cnt;
        fork
            run_load(MD, MD, MD, 0, 1'b1, 500, 2 * NPOS + 2);
            begin
                tick();
                for (t = 0; t < 100 && cnt_b < 3; t++) tick();
                io.start = 1'b1;
                tick();
                io.start = 1'b0;
            end
        join
        repeat (6) tick();
        check("single_load_done", done_cnt - d0, 1);
        check("ignored_start_a_count", cnt_a, NPOS);
        check("ignored_start_b_count", cnt_b, NPOS);
        check("ignored_start_busy", io.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
